ultrasonic_echo_responder: RTL and testbench

- Cycle-accurate behavioural responder for the HC-SR04-style ultrasonic ranging interface. It is the far end of the trig/echo protocol that the sensor driver initiates.
- Accepts the driver's trig pulse and returns an echo pulse whose width encodes a programmable target distance.
- Used in simulation benches and in FPGA loopback builds, where it stands in for the physical sensor.

---
 rtl/ultrasonic_echo_responder.sv | 144 ++++++++++++++
 tb/tb_ultrasonic_echo_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_echo_responder.sv
// rtl/ultrasonic_echo_responder.sv - HC-SR04 style trig/echo responder (optional macro: ECHO_JITTER_EN)
module ultrasonic_echo_responder #(
  parameter int unsigned MIN_TRIG_CYC = 500,
  parameter int unsigned BURST_CYC    = 10000,
  parameter int unsigned CYC_PER_CM   = 2942,
  parameter int unsigned TIMEOUT_CYC  = 1900000,
  parameter int unsigned HOLDOFF_CYC  = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [7:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  localparam logic [23:0] LP_MIN_TRIG   = 24'(MIN_TRIG_CYC);
  localparam logic [23:0] LP_BURST_LAST = 24'(BURST_CYC - 1);
  localparam logic [23:0] LP_TIMEOUT    = 24'(TIMEOUT_CYC);
  localparam logic [23:0] LP_HOLD_LAST  = 24'(HOLDOFF_CYC - 1);
  localparam logic [11:0] LP_CPC        = 12'(CYC_PER_CM);
  localparam logic [23:0] LP_CNT_MAX    = 24'hFF_FFFF;

  state_t      r_state;
  logic [23:0] r_counter;
  logic [23:0] r_echo_len;
  logic        r_trig_q;

  logic        w_rise;
  logic [19:0] w_prod;
  logic [23:0] w_base_len;
  logic [23:0] w_echo_len_next;

  // trig was sampled low last cycle and is high now
  assign w_rise     = trig & ~r_trig_q;
  // 8x12 product fits in 20 bits; distance 0 means no object, so report timeout width
  assign w_prod     = 20'(distance_cm) * 20'(LP_CPC);
  assign w_base_len = (distance_cm == 8'd0) ? LP_TIMEOUT : {4'b0000, w_prod};

`ifdef ECHO_JITTER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci taps 16,14,13,11
  assign w_lfsr_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  // a few cycles of jitter stay well below one cm of readback
  assign w_echo_len_next = w_base_len + {18'b0, r_lfsr[5:0]};

  // LFSR steps once for every accepted trig
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (r_state == S_IDLE && w_rise) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end
`else
  assign w_echo_len_next = w_base_len;
`endif

  // main sequencer: trig qualification, burst delay, echo width, holdoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_counter  <= 24'd0;
      r_echo_len <= 24'd0;
      r_trig_q   <= 1'b1;
      echo       <= 1'b0;
      busy       <= 1'b0;
      trig_err   <= 1'b0;
    end else begin
      r_trig_q <= trig;
      trig_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state   <= S_TRIG_HI;
            r_counter <= 24'd1;
            busy      <= 1'b1;
          end
        end
        S_TRIG_HI: begin
          if (trig) begin
            if (r_counter != LP_CNT_MAX) begin
              r_counter <= r_counter + 24'd1;
            end
          end else if (r_counter >= LP_MIN_TRIG) begin
            r_state    <= S_BURST;
            r_counter  <= 24'd0;
            r_echo_len <= w_echo_len_next;
          end else begin
            r_state   <= S_IDLE;
            r_counter <= 24'd0;
            busy      <= 1'b0;
            trig_err  <= 1'b1;
          end
        end
        S_BURST: begin
          if (r_counter == LP_BURST_LAST) begin
            r_state   <= S_ECHO;
            r_counter <= 24'd0;
            echo      <= 1'b1;
          end else begin
            r_counter <= r_counter + 24'd1;
          end
        end
        S_ECHO: begin
          if (r_counter == r_echo_len - 24'd1) begin
            r_state   <= S_HOLDOFF;
            r_counter <= 24'd0;
            echo      <= 1'b0;
          end else begin
            r_counter <= r_counter + 24'd1;
          end
        end
        S_HOLDOFF: begin
          if (r_counter == LP_HOLD_LAST) begin
            r_state   <= S_IDLE;
            r_counter <= 24'd0;
            busy      <= 1'b0;
          end else begin
            r_counter <= r_counter + 24'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_counter <= 24'd0;
          echo      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// tb/tb_ultrasonic_echo_responder.sv - directed bench for ultrasonic_echo_responder
module tb_ultrasonic_echo_responder;

  localparam int MIN_T = 8;
  localparam int BURST = 30;
  localparam int CPC   = 11;
  localparam int TOUT  = 100;
  localparam int HOLD  = 60;
  localparam int BOUND = 5000;

  logic       clk;
  logic       rst;
  logic       trig;
  logic [7:0] distance_cm;
  logic       echo;
  logic       busy;
  logic       trig_err;

  int cyc;
  int err_pulses;
  int errors;
  int checks;

  ultrasonic_echo_responder #(
    .MIN_TRIG_CYC(MIN_T),
    .BURST_CYC   (BURST),
    .CYC_PER_CM  (CPC),
    .TIMEOUT_CYC (TOUT),
    .HOLDOFF_CYC (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .distance_cm(distance_cm),
    .echo       (echo),
    .busy       (busy),
    .trig_err   (trig_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge index of the most recent rising clock edge
  always @(posedge clk) cyc <= cyc + 1;

  // count every trig_err cycle the DUT produces
  always @(negedge clk) if (trig_err === 1'b1) err_pulses <= err_pulses + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      0:       return echo;
      1:       return busy;
      default: return trig_err;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, output int at, output int ok);
    ok = 0;
    at = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (cur(sel) === val) begin
        ok = 1;
        at = cyc;
        break;
      end
    end
  endtask

  // called at a negedge; returns the edge index F that first samples trig low
  task automatic trig_pulse(input int n, output int f);
    trig = 1'b1;
    repeat (n) @(negedge clk);
    trig = 1'b0;
    f = cyc + 1;
  endtask

  int f, rise, fall, bfall, ok, ep;

  initial begin
    cyc = 0; err_pulses = 0; errors = 0; checks = 0;
    rst = 1'b1; trig = 1'b0; distance_cm = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_echo", echo, 0);
    check("reset_busy", busy, 0);
    check("reset_trig_err", trig_err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // minimum valid trig, distance 20, distance changed to 100 during burst
    distance_cm = 8'd20;
    trig_pulse(MIN_T, f);
    @(negedge clk);
    check("d20_busy_after_f", busy, 1);
    repeat (5) @(negedge clk);
    distance_cm = 8'd100;
    wait_sig(0, 1'b1, rise, ok);
    check("d20_rise_seen", ok, 1);
    check("d20_burst_delay", rise - f, BURST);
    check("d20_busy_at_rise", busy, 1);
    wait_sig(0, 1'b0, fall, ok);
    check("d20_width", fall - rise, 20 * CPC);
    check("d20_busy_at_fall", busy, 1);
    wait_sig(1, 1'b0, bfall, ok);
    check("d20_holdoff", bfall - fall, HOLD);
    check("d20_no_err", err_pulses, 0);

    // one cycle short of the minimum trig width
    repeat (2) @(negedge clk);
    trig_pulse(MIN_T - 1, f);
    check("short_busy_trig_hi", busy, 1);
    @(negedge clk);
    check("short_at_f_cycle", cyc, f);
    check("short_err_at_f", trig_err, 1);
    check("short_busy_at_f", busy, 0);
    check("short_echo_at_f", echo, 0);
    @(negedge clk);
    check("short_err_one_cycle", trig_err, 0);
    check("short_err_count", err_pulses, 1);

    // no object: timeout width then full holdoff
    repeat (2) @(negedge clk);
    distance_cm = 8'd0;
    trig_pulse(MIN_T + 3, f);
    wait_sig(0, 1'b1, rise, ok);
    check("tout_burst_delay", rise - f, BURST);
    wait_sig(0, 1'b0, fall, ok);
    check("tout_width", fall - rise, TOUT);
    wait_sig(1, 1'b0, bfall, ok);
    check("tout_holdoff", bfall - fall, HOLD);

    // trigs during ECHO and HOLDOFF are ignored; one right after busy falls is taken
    repeat (2) @(negedge clk);
    distance_cm = 8'd3;
    trig_pulse(MIN_T, f);
    wait_sig(0, 1'b1, rise, ok);
    ep = err_pulses;
    repeat (2) @(negedge clk);
    trig_pulse(12, f);
    wait_sig(0, 1'b0, fall, ok);
    check("ign_echo_width", fall - rise, 3 * CPC);
    repeat (5) @(negedge clk);
    trig_pulse(12, f);
    check("ign_busy_in_holdoff", busy, 1);
    wait_sig(1, 1'b0, bfall, ok);
    check("ign_holdoff_len", bfall - fall, HOLD);
    check("ign_no_err", err_pulses, ep);
    trig_pulse(MIN_T, f);
    check("next_trig_busy", busy, 1);
    wait_sig(0, 1'b1, rise, ok);
    check("next_trig_rise_seen", ok, 1);
    check("next_trig_delay", rise - f, BURST);
    wait_sig(1, 1'b0, bfall, ok);

    // reset in the middle of ECHO
    repeat (2) @(negedge clk);
    distance_cm = 8'd10;
    trig_pulse(MIN_T, f);
    wait_sig(0, 1'b1, rise, ok);
    repeat (50) @(negedge clk);
    check("pre_rst_echo", echo, 1);
    rst = 1'b1;
    #1;
    check("rst_echo_async", echo, 0);
    check("rst_busy_async", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    distance_cm = 8'd255;
    trig_pulse(MIN_T, f);
    wait_sig(0, 1'b1, rise, ok);
    check("d255_burst_delay", rise - f, BURST);
    wait_sig(0, 1'b0, fall, ok);
    check("d255_width", fall - rise, 255 * CPC);
    wait_sig(1, 1'b0, bfall, ok);

    // trig already high at reset release is not a trigger
    trig = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("held_trig_not_taken", busy, 0);
    trig = 1'b0;
    repeat (2) @(negedge clk);
    check("held_trig_release_idle", busy, 0);
    check("held_trig_no_echo", echo, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
